// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_unit : in-order instruction fetch with prefetch FIFO and redirect |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        IFIDWrite,
  output logic [31:0] PC,
  output logic [31:0] Instruct,
  output logic        Stall
);

  localparam int              c_AW      = $clog2(FIFO_DEPTH);
  localparam int              c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_deliver_pc;
  logic [31:0]     r_fifo [FIFO_DEPTH];
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_inflight;
  logic [c_CW-1:0] r_drop_cnt;

  logic [c_CW-1:0] w_inflight_next;
  logic [c_CW-1:0] w_drop_next;
  logic [c_CW:0]   w_used;
  logic            w_active;
  logic            w_redirect;
  logic            w_issue;
  logic            w_ret;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_redirect_pc;
  logic            w_unused;

  assign w_active      = (r_state != ST_IDLE);
  assign w_redirect    = redirect & w_active;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirect_pc[1:0]};
  assign w_used        = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_ret         = imem_rvalid & w_active;
  assign w_issue       = imem_req & imem_gnt;
  assign imem_addr     = r_fetch_pc;

  // Credits cover both outstanding reads and buffered words, so a return can never hit a full FIFO.
  assign w_inflight_next = r_inflight + c_CW'(w_issue) - c_CW'(w_ret);
  assign w_push          = w_ret & (r_state == ST_FETCH) & ~w_redirect;
  assign w_pop           = ~Stall & IFIDWrite & ~w_redirect;

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (w_redirect) begin
      w_drop_next = w_inflight_next;
    end else if ((r_state == ST_DRAIN) && w_ret && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - c_CNT_ONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = (w_used < {1'b0, c_DEPTH}) & ~w_redirect;
        if (w_redirect && (w_inflight_next != '0)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drop_next == '0) begin
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign Stall    = (r_count == '0);
  assign Instruct = Stall ? 32'h0 : r_fifo[r_rd_ptr];
  assign PC       = r_deliver_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_deliver_pc <= RESET_PC;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_inflight   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_inflight_next;
      r_drop_cnt <= w_drop_next;
      if (w_redirect) begin
        r_fetch_pc   <= w_redirect_pc;
        r_deliver_pc <= w_redirect_pc;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
          r_deliver_pc <= r_deliver_pc + 32'd4;
        end
        r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_fetch_unit : scoreboard bench with a variable-latency memory model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        IFIDWrite;
  logic [31:0] PC;
  logic [31:0] Instruct;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } sb_t;

  pend_t       pend[$];
  sb_t         sb[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          deliv_cnt = 0;
  int          issue_cnt = 0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_issue = 32'h0;
  logic [31:0] exp_fetch = RESET_PC;
  logic        prev_redirect = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IFIDWrite   (IFIDWrite),
    .PC          (PC),
    .Instruct    (Instruct),
    .Stall       (Stall)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model plus scoreboard, evaluated mid-cycle when everything is stable.
  task automatic monitor_loop();
    pend_t p;
    sb_t   e;
    int    d;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend.delete();
        sb.delete();
        exp_fetch     = RESET_PC;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        last_due      = 0;
        prev_redirect = 1'b0;
      end else begin
        if (Stall) begin
          checks++;
          if (Instruct !== 32'h0) begin
            errors++;
            $display("FAIL stall_instr got=%h required=00000000", Instruct);
          end
        end
        if (prev_redirect) begin
          checks++;
          if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_after_redirect got=%b required=1", Stall);
          end
        end
        if (!Stall && IFIDWrite && !redirect) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected got pc=%h ins=%h required=nothing", PC, Instruct);
          end else begin
            e = sb.pop_front();
            if (PC !== e.pc || Instruct !== e.ins) begin
              errors++;
              $display("FAIL deliver got pc=%h ins=%h required pc=%h ins=%h", PC, Instruct, e.pc, e.ins);
            end
          end
          deliv_cnt++;
          last_pc = PC;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p           = pend.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata  = p.data;
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
        if (imem_req && imem_gnt) begin
          checks++;
          if (redirect || imem_addr !== exp_fetch) begin
            errors++;
            $display("FAIL issue got addr=%h redirect=%b required addr=%h redirect=0", imem_addr, redirect, exp_fetch);
          end
          issue_cnt++;
          last_issue = imem_addr;
          e.pc  = exp_fetch;
          e.ins = memf(exp_fetch);
          sb.push_back(e);
          d = cyc + int'($urandom_range(lat_max, lat_min));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          p.due  = d;
          p.data = memf(imem_addr);
          pend.push_back(p);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect) begin
          sb.delete();
          exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end
        prev_redirect = redirect;
      end
    end
  endtask

  task automatic wait_deliv(input int n, input int bound, input string name);
    int target = deliv_cnt + n;
    int k = 0;
    while (deliv_cnt < target && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (deliv_cnt < target) begin
      errors++;
      $display("FAIL %s_deliver_timeout got=%0d required=%0d", name, deliv_cnt, target);
    end
  endtask

  task automatic wait_issue(input int bound, input string name);
    int target = issue_cnt + 1;
    int k = 0;
    while (issue_cnt < target && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (issue_cnt < target) begin
      errors++;
      $display("FAIL %s_issue_timeout got=%0d required=%0d", name, issue_cnt, target);
    end
  endtask

  task automatic wait_two_inflight(input string name);
    int k = 0;
    while (pend.size() < 2 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (pend.size() < 2) begin
      errors++;
      $display("FAIL %s_inflight got=%0d required=2", name, pend.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || Stall !== 1'b1 || Instruct !== 32'h0 || PC !== RESET_PC) begin
      errors++;
      $display("FAIL reset_outputs got req=%b stall=%b ins=%h pc=%h required req=0 stall=1 ins=0 pc=%h",
               imem_req, Stall, Instruct, PC, RESET_PC);
    end
    reset = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got=%b required=0", imem_req);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_issue got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    tick();
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass got stall=%b required=1", Stall);
    end
    tick();
    checks++;
    if (Stall !== 1'b0 || PC !== RESET_PC || Instruct !== memf(RESET_PC)) begin
      errors++;
      $display("FAIL first_deliver got stall=%b pc=%h ins=%h required stall=0 pc=%h ins=%h",
               Stall, PC, Instruct, RESET_PC, memf(RESET_PC));
    end
  endtask

  task automatic test_stream();
    wait_deliv(8, 60, "stream");
    checks++;
    if (last_pc !== 32'(4 * (deliv_cnt - 1))) begin
      errors++;
      $display("FAIL stream_pc got=%h required=%h", last_pc, 32'(4 * (deliv_cnt - 1)));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_pc;
    logic [31:0] held_ins;
    IFIDWrite = 1'b0;
    tick();
    tick();
    held_pc  = PC;
    held_ins = Instruct;
    checks++;
    if (sb.size() == 0 || Stall !== 1'b0 || PC !== sb[0].pc || Instruct !== sb[0].ins) begin
      errors++;
      $display("FAIL bp_head got stall=%b pc=%h ins=%h required stall=0 and scoreboard head", Stall, PC, Instruct);
    end
    repeat (3) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_req got=%b required=0", imem_req);
      end
      tick();
      checks++;
      if (PC !== held_pc || Instruct !== held_ins) begin
        errors++;
        $display("FAIL bp_hold got pc=%h ins=%h required pc=%h ins=%h", PC, Instruct, held_pc, held_ins);
      end
    end
    IFIDWrite = 1'b1;
  endtask

  task automatic test_redirect();
    lat_min = 3;
    lat_max = 3;
    wait_two_inflight("redir");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_req got=%b required=0", imem_req);
    end
    tick();
    redirect = 1'b0;
    wait_issue(20, "redir");
    checks++;
    if (last_issue !== 32'h0000_0100) begin
      errors++;
      $display("FAIL redir_issue got=%h required=00000100", last_issue);
    end
    wait_deliv(1, 30, "redir");
    checks++;
    if (last_pc !== 32'h0000_0100) begin
      errors++;
      $display("FAIL redir_first_pc got=%h required=00000100", last_pc);
    end
  endtask

  task automatic test_drain_redirect();
    wait_two_inflight("drain");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_pc = 32'h0000_0200;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL drain_req got=%b required=0", imem_req);
    end
    tick();
    redirect = 1'b0;
    wait_issue(20, "drain");
    checks++;
    if (last_issue !== 32'h0000_0200) begin
      errors++;
      $display("FAIL drain_issue got=%h required=00000200", last_issue);
    end
    wait_deliv(1, 30, "drain");
    checks++;
    if (last_pc !== 32'h0000_0200) begin
      errors++;
      $display("FAIL drain_first_pc got=%h required=00000200", last_pc);
    end
    wait_deliv(3, 30, "drain_tail");
  endtask

  task automatic test_gnt_low();
    logic [31:0] held_addr;
    int k = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (6) tick();
    imem_gnt = 1'b0;
    while (imem_req !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    held_addr = imem_addr;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_fetch) begin
      errors++;
      $display("FAIL gnt_low_req got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_fetch);
    end
    repeat (4) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
        errors++;
        $display("FAIL gnt_low_hold got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, held_addr);
      end
    end
    checks++;
    if (Stall !== 1'b1 || Instruct !== 32'h0) begin
      errors++;
      $display("FAIL gnt_low_empty got stall=%b ins=%h required stall=1 ins=00000000", Stall, Instruct);
    end
    imem_gnt = 1'b1;
    wait_deliv(2, 20, "gnt_low");
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_deliv(1, 30, "wrap");
    checks++;
    if (last_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top got=%h required=fffffffc", last_pc);
    end
    wait_deliv(1, 30, "wrap");
    checks++;
    if (last_pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_zero got=%h required=00000000", last_pc);
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      imem_gnt    = ($urandom_range(3, 0) != 0);
      IFIDWrite   = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(29, 0) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect  = 1'b0;
    imem_gnt  = 1'b1;
    IFIDWrite = 1'b1;
    wait_deliv(4, 60, "random");
  endtask

  initial begin
    reset       = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    IFIDWrite   = 1'b1;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_drain_redirect();
    test_gnt_low();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
